// File: rtl/ram1_pkg.sv
// RAM1 reminder scanner shared definitions: default geometry,
// medicine-table field slices and scanner FSM encoding.
package ram1_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    localparam int MEDID_HI = 7;
    localparam int MEDID_LO = 4;
    localparam int FREQ_HI  = 3;
    localparam int FREQ_LO  = 0;
    localparam int MEDID_W  = MEDID_HI - MEDID_LO + 1;
    localparam int FREQ_W   = FREQ_HI - FREQ_LO + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_EVAL,
        S_NOTIFY
    } state_t;

endpackage

// File: rtl/ram1_slot_counter_bank.sv
// Per-slot dose countdowns, one read/write port at the
// slot currently being scanned.
module ram1_slot_counter_bank #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] idx,
    input  logic              we,
    input  logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    logic [CNT_W-1:0] cnt_q [2**ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (we) begin
            cnt_q[idx] <= wr_cnt;
        end
    end

    assign rd_cnt = cnt_q[idx];

endmodule

// File: rtl/ram1_reminder_scanner.sv
// Walks the RAM1 medicine table on every Tick, counts each slot
// down and raises a valid/ack reminder when a slot falls due.
module ram1_reminder_scanner
    import ram1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Tick,
    output logic [ADDR_W-1:0]  R_Addr,
    input  logic [DATA_W-1:0]  R_Data,
    output logic               Rem_Valid,
    output logic [MEDID_W-1:0] Rem_MedID,
    input  logic               Rem_Ack,
    output logic               Busy,
    output logic               Overrun
);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic [MEDID_W-1:0]  medid_d;
    logic                busy_d;
    logic                pend_q;
    logic                pend_d;
    logic                ovr_d;

    logic                cnt_we;
    logic [CNT_W-1:0]    cnt_wr;
    logic [CNT_W-1:0]    cnt_rd;

    logic [FREQ_W-1:0]   freq;
    logic [CNT_W-1:0]    f_ext;
    logic                last_slot;
    logic                is_empty;
    logic                is_due;
    logic                is_stale;

    ram1_slot_counter_bank #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk    (Clk),
        .rst_n  (Rst),
        .idx    (R_Addr),
        .we     (cnt_we),
        .wr_cnt (cnt_wr),
        .rd_cnt (cnt_rd)
    );

    assign freq      = data_q[FREQ_HI:FREQ_LO];
    assign f_ext     = CNT_W'(freq);
    assign last_slot = &R_Addr;
    assign is_empty  = (freq == '0);
    assign is_due    = !is_empty && (cnt_rd <= CNT_W'(1));
    // A count above Freq means the slot was rewritten with a shorter period
    assign is_stale  = !is_empty && !is_due && (cnt_rd > f_ext);

    always_comb begin
        state_d = state_q;
        addr_d  = R_Addr;
        data_d  = data_q;
        valid_d = Rem_Valid;
        medid_d = Rem_MedID;
        busy_d  = Busy;
        pend_d  = pend_q;
        ovr_d   = Overrun;
        cnt_we  = 1'b0;
        cnt_wr  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (Tick || pend_q) begin
                    pend_d  = 1'b0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = R_Data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                cnt_we = 1'b1;
                unique case (1'b1)
                    is_empty: cnt_wr = '0;
                    is_due:   cnt_wr = f_ext;
                    is_stale: cnt_wr = f_ext;
                    default:  cnt_wr = cnt_rd - CNT_W'(1);
                endcase
                if (is_due) begin
                    valid_d = 1'b1;
                    medid_d = data_q[MEDID_HI:MEDID_LO];
                    state_d = S_NOTIFY;
                end else if (last_slot) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = R_Addr + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_NOTIFY: begin
                if (Rem_Ack) begin
                    valid_d = 1'b0;
                    if (last_slot) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = R_Addr + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Tick && (state_q != S_IDLE)) begin
            if (pend_q) ovr_d = 1'b1;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            R_Addr    <= '0;
            data_q    <= '0;
            Rem_Valid <= 1'b0;
            Rem_MedID <= '0;
            Busy      <= 1'b0;
            pend_q    <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            R_Addr    <= addr_d;
            data_q    <= data_d;
            Rem_Valid <= valid_d;
            Rem_MedID <= medid_d;
            Busy      <= busy_d;
            pend_q    <= pend_d;
            Overrun   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_ram1_reminder_scanner.sv
// Bench for ram1_reminder_scanner: RAM1 model with 1-cycle read,
// table-level reference of due reminders per tick.
module tb_ram1_reminder_scanner;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tick = 1'b0;
    logic       Rem_Ack = 1'b0;
    logic [3:0] R_Addr;
    logic [7:0] R_Data;
    logic       Rem_Valid;
    logic [3:0] Rem_MedID;
    logic       Busy;
    logic       Overrun;

    logic [7:0] mem [16];
    int         mcnt [16];
    int         exp_q [$];
    int         got [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         rises;
    int         bcyc;
    int         vcyc;
    bit         tmo;
    int         pat2 [5] = '{1, 0, 1, 0, 1};
    int         pat5 [11] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    ram1_reminder_scanner dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Tick      (Tick),
        .R_Addr    (R_Addr),
        .R_Data    (R_Data),
        .Rem_Valid (Rem_Valid),
        .Rem_MedID (Rem_MedID),
        .Rem_Ack   (Rem_Ack),
        .Busy      (Busy),
        .Overrun   (Overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) R_Data <= mem[R_Addr];

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) mcnt[s] = 0;
    endtask

    // One dose-time unit: which MedIDs come due, in slot order
    task automatic model_tick();
        for (int s = 0; s < 16; s++) begin
            int f;
            int c;
            f = int'(mem[s][3:0]);
            c = mcnt[s];
            if (f == 0) begin
                mcnt[s] = 0;
            end else if (c <= 1) begin
                mcnt[s] = f;
                exp_q.push_back(int'(mem[s][7:4]));
            end else if (c > f) begin
                mcnt[s] = f;
            end else begin
                mcnt[s] = c - 1;
            end
        end
    endtask

    task automatic pulse_tick();
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!Rem_Valid && g < 200) begin
            g++;
            @(negedge Clk);
        end
        chk(tag, Rem_Valid, 1);
    endtask

    task automatic observe(input bit ack_rand, input int tick_at);
        int  idle_run = 0;
        int  guard = 0;
        bit  prev_busy;
        bit  held = 0;
        bit  ack;
        logic [3:0] prev_id = '0;
        prev_busy = Busy;
        rises = 0;
        bcyc = 0;
        vcyc = 0;
        got.delete();
        while (idle_run < 3 && guard < 3000) begin
            Tick = 1'b0;
            if (Busy) begin
                bcyc++;
                idle_run = 0;
                if (bcyc == tick_at) Tick = 1'b1;
            end else begin
                idle_run++;
            end
            if (Busy && !prev_busy) rises++;
            if (Rem_Valid) begin
                vcyc++;
                if (held) chk("medid_stable", Rem_MedID, prev_id);
            end
            ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            Rem_Ack = ack;
            if (Rem_Valid && ack) got.push_back(int'(Rem_MedID));
            held = Rem_Valid && !ack;
            prev_id = Rem_MedID;
            prev_busy = Busy;
            guard++;
            @(negedge Clk);
        end
        Tick = 1'b0;
        tmo = (guard >= 3000);
    endtask

    task automatic cmp_lists(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_medid"}, got[i], exp_q[i]);
    endtask

    task automatic tick_and_check(input string tag, input bit ack_rand,
                                  input int exp_n);
        exp_q.delete();
        model_tick();
        pulse_tick();
        observe(ack_rand, -1);
        chk({tag, "_timeout"}, tmo, 0);
        chk({tag, "_scans"}, rises, 0);
        cmp_lists(tag);
        chk({tag, "_cycles"}, bcyc, 48 + vcyc);
        chk({tag, "_valid_end"}, Rem_Valid, 0);
        if (exp_n >= 0) chk({tag, "_n"}, got.size(), exp_n);
    endtask

    initial begin
        for (int s = 0; s < 16; s++) mem[s] = 8'h00;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_raddr", R_Addr, 0);
        chk("rst_valid", Rem_Valid, 0);
        chk("rst_medid", Rem_MedID, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_overrun", Overrun, 0);
        Rst = 1'b1;
        @(negedge Clk);

        // reset in the middle of a held reminder
        mem[3] = 8'h52;
        Rem_Ack = 1'b0;
        pulse_tick();
        wait_valid("t1_valid");
        Rst = 1'b0;
        #1;
        chk("t1_valid_drop", Rem_Valid, 0);
        chk("t1_busy_drop", Busy, 0);
        chk("t1_raddr_zero", R_Addr, 0);
        chk("t1_medid_zero", Rem_MedID, 0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 5; i++) tick_and_check("t2", 0, pat2[i]);

        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        for (int s = 0; s < 16; s++) mem[s] = 8'h00;
        mem[1] = 8'h21;
        mem[9] = 8'h71;
        @(negedge Clk);
        exp_q.delete();
        model_tick();
        Rem_Ack = 1'b0;
        pulse_tick();
        wait_valid("t3_valid");
        repeat (20) begin
            chk("t3_hold_valid", Rem_Valid, 1);
            chk("t3_hold_id", Rem_MedID, 2);
            chk("t3_hold_addr", R_Addr, 1);
            @(negedge Clk);
        end
        observe(0, -1);
        chk("t3_timeout", tmo, 0);
        cmp_lists("t3_order");
        chk("t3_second", got.size() > 1 ? got[1] : -1, 7);

        exp_q.delete();
        model_tick();
        model_tick();
        Rem_Ack = 1'b0;
        pulse_tick();
        wait_valid("t4_valid");
        pulse_tick();
        chk("t4_single_pend", Overrun, 0);
        @(negedge Clk);
        pulse_tick();
        chk("t4_overrun", Overrun, 1);
        observe(0, -1);
        chk("t4_timeout", tmo, 0);
        chk("t4_extra_scans", rises, 1);
        cmp_lists("t4_list");
        chk("t4_overrun_hold", Overrun, 1);
        tick_and_check("t4_after", 0, 2);
        chk("t4_sticky", Overrun, 1);

        Rst = 1'b0;
        @(negedge Clk);
        chk("t5_ovr_reset", Overrun, 0);
        Rst = 1'b1;
        model_reset();
        for (int s = 0; s < 16; s++) mem[s] = 8'h00;
        mem[4] = 8'h39;
        @(negedge Clk);
        for (int i = 0; i < 11; i++) begin
            if (i == 3) mem[4] = 8'h33;
            if (i == 7) mem[4] = 8'h30;
            tick_and_check("t5", 0, pat5[i]);
        end

        Rem_Ack = 1'b1;
        @(negedge Clk);
        chk("t6_ack_idle_valid", Rem_Valid, 0);
        chk("t6_ack_idle_busy", Busy, 0);
        Rem_Ack = 1'b0;
        @(negedge Clk);
        exp_q.delete();
        model_tick();
        model_tick();
        pulse_tick();
        observe(1, 48);
        chk("t6_timeout", tmo, 0);
        chk("t6_queued_scan", rises, 1);
        chk("t6_cycles", bcyc, 96 + vcyc);
        cmp_lists("t6_list");
        chk("t6_no_overrun", Overrun, 0);

        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 16; s++) begin
                logic [3:0] id;
                logic [3:0] fq;
                id = 4'($urandom_range(0, 15));
                fq = ($urandom_range(0, 9) < 4) ? 4'd0
                                                : 4'($urandom_range(1, 15));
                mem[s] = {id, fq};
            end
            for (int t = 0; t < 4; t++) begin
                if (t == 2) mem[$urandom_range(0, 15)] = 8'($urandom());
                tick_and_check("rnd", 1, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
